// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war scoreboard.
package tug_pkg;

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    HOLD    = 2'd1,
    RESTART = 2'd2,
    OVER    = 2'd3
  } state_t;

  // Active-low segment codes, bit order gfedcba.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

endpackage

// File: rtl/tug_scoreboard_seg7_digit.sv
// 4-bit value to active-low 7-segment code; blank above 9.
module seg7_digit
  import tug_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  // Table lookup, guarded so out-of-range values blank the display.
  always_comb begin
    seg = SEG_BLANK;
    if (value < 4'd10) seg = SEG_DIGIT[value];
  end

endmodule

// File: rtl/tug_scoreboard.sv
// Round scoreboard for the tug-of-war playfield: edge-detects win levels,
// keeps per-player scores, pulses a playfield restart and declares a winner.
module tug_scoreboard
  import tug_pkg::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       left_win,
  input  logic       right_win,
  output logic       game_restart,
  output logic [6:0] hex_left,
  output logic [6:0] hex_right,
  output logic       match_over,
  output logic [1:0] match_winner
);

  localparam int SW = $clog2(WIN_SCORE + 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t          state, state_n;
  logic [SW-1:0]   left_score, left_score_n;
  logic [SW-1:0]   right_score, right_score_n;
  logic [HW-1:0]   hold_cnt, hold_cnt_n;
  logic [1:0]      winner, winner_n;
  logic            left_q, right_q;
  logic            ev_left, ev_right, hit_left, hit_right;

  // Previous-cycle copies of the win levels for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      left_q  <= left_win;
      right_q <= right_win;
    end
  end

  assign ev_left   = left_win  & ~left_q;
  assign ev_right  = right_win & ~right_q;
  // A tie (both rising together) is discarded entirely.
  assign hit_left  = ev_left  & ~ev_right;
  assign hit_right = ev_right & ~ev_left;

  // State, score, hold counter and winner registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= PLAY;
      left_score  <= '0;
      right_score <= '0;
      hold_cnt    <= '0;
      winner      <= WIN_NONE;
    end else begin
      state       <= state_n;
      left_score  <= left_score_n;
      right_score <= right_score_n;
      hold_cnt    <= hold_cnt_n;
      winner      <= winner_n;
    end
  end

  // Next-state logic; clear overrides every transition.
  always_comb begin
    state_n       = state;
    left_score_n  = left_score;
    right_score_n = right_score;
    hold_cnt_n    = hold_cnt;
    winner_n      = winner;
    if (clear) begin
      state_n       = RESTART;
      left_score_n  = '0;
      right_score_n = '0;
      winner_n      = WIN_NONE;
    end else begin
      unique case (state)
        PLAY: begin
          if (hit_left) begin
            left_score_n = left_score + SW'(1);
            if (left_score_n == SW'(WIN_SCORE)) begin
              state_n  = OVER;
              winner_n = WIN_LEFT;
            end else begin
              state_n    = HOLD;
              hold_cnt_n = HW'(HOLD_CYCLES - 1);
            end
          end else if (hit_right) begin
            right_score_n = right_score + SW'(1);
            if (right_score_n == SW'(WIN_SCORE)) begin
              state_n  = OVER;
              winner_n = WIN_RIGHT;
            end else begin
              state_n    = HOLD;
              hold_cnt_n = HW'(HOLD_CYCLES - 1);
            end
          end
        end
        HOLD: begin
          if (hold_cnt == '0) state_n = RESTART;
          else                hold_cnt_n = hold_cnt - HW'(1);
        end
        RESTART: state_n = PLAY;
        OVER:    state_n = OVER;
        default: state_n = PLAY;
      endcase
    end
  end

  assign game_restart = (state == RESTART);
  assign match_over   = (state == OVER);
  assign match_winner = winner;

  seg7_digit u_seg_left  (.value(4'(left_score)),  .seg(hex_left));
  seg7_digit u_seg_right (.value(4'(right_score)), .seg(hex_right));

endmodule
